pll_reset_sequencer: RTL and testbench

- Sequences the 148.5 MHz video PLL: drives its reset, waits for lock, qualifies lock stability, then releases the video-domain reset.
- Re-locks automatically on loss of lock; retries on lock timeout and flags a fault after MAX_RETRIES failures.
- Runs in the 50 MHz reference clock domain, between the board reset and the PLL/HDMI pipeline reset tree.

---
 rtl/pll_reset_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//   Brings up the video PLL from the reference clock domain. It pulses the
//   PLL reset, waits for lock, requires lock to hold steadily, and then
//   releases the video-domain reset. Loss of lock in RUN restarts the
//   sequence. Lock timeouts are retried, and the block enters FAULT after
//   MAX_RETRIES consecutive failures.
//
//   Optional feature macro: PLL_SEQ_LOSS_COUNTER_EN
//     defined   -> lock_loss_cnt is an 8-bit saturating count of lock losses
//     undefined -> lock_loss_cnt is tied to zero
//
// Ports
//   refclk         in   reference clock; all logic on its rising edge
//   rst_n          in   asynchronous active-low reset
//   pll_locked     in   PLL lock, asynchronous to refclk (2-FF synchronized)
//   sw_reset_req   in   single-cycle request to restart the sequence
//   pll_rst        out  active-high PLL reset
//   video_rst_n    out  active-low video-domain reset
//   ready          out  high only in RUN
//   fault          out  high only in FAULT
//   retry_cnt      out  failed attempts since last success / sw_reset_req
//   lock_loss_cnt  out  lock losses seen in RUN
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 500,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       MaxRetries  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStabilize,
    StRun,
    StFault
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic             lock_meta_q, lock_s_q;
  logic             pll_rst_q, video_rst_n_q, ready_q, fault_q;

  // Lock synchronizer: pll_locked is not used anywhere else.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retry_d   = retry_q;
    retry_inc = retry_q + 4'd1;
    unique case (state_q)
      StResetPll: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        if (lock_s_q) begin
          state_d = StStabilize;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          state_d = (retry_inc == MaxRetries) ? StFault : StResetPll;
        end
      end
      StStabilize: begin
        // A lock drop opens a fresh timeout window without costing a retry.
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_s_q) state_d = StResetPll;
      end
      StFault: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StResetPll;
        cnt_d   = '0;
      end
    endcase
    if (sw_reset_req) begin
      state_d = StResetPll;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StResetPll;
      cnt_q         <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      video_rst_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= (state_d == StResetPll) || (state_d == StFault);
      video_rst_n_q <= (state_d == StRun);
      ready_q       <= (state_d == StRun);
      fault_q       <= (state_d == StFault);
    end
  end

`ifdef PLL_SEQ_LOSS_COUNTER_EN
  logic [7:0] loss_q;

  // Counts even when sw_reset_req coincides with the loss.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if ((state_q == StRun) && !lock_s_q && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_rst     = pll_rst_q;
  assign video_rst_n = video_rst_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//   Directed, table-driven bench for pll_reset_sequencer with small timing
//   parameters (pulse 4, timeout 20, stable 8, retries 2). Each table row
//   applies inputs at a falling edge, lets the given number of cycles pass,
//   and compares all outputs at the falling edge. The asynchronous reset
//   case is checked by hand between clock edges.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       pll_rst;
  logic       video_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

`ifdef PLL_SEQ_LOSS_COUNTER_EN
  localparam bit LossEn = 1'b1;
`else
  localparam bit LossEn = 1'b0;
`endif

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .CNT_W              (16)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .sw_reset_req (sw_reset_req),
    .pll_rst      (pll_rst),
    .video_rst_n  (video_rst_n),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    string       name;
    int unsigned cycles;
    logic        rst_n;
    logic        locked;
    logic        sw;
    logic        pll_rst;
    logic        vrst_n;
    logic        ready;
    logic        fault;
    logic [3:0]  retry;
    logic [7:0]  loss;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(string n, int unsigned c, logic r, logic l, logic s,
                              logic pr, logic vr, logic rd, logic ft,
                              logic [3:0] rt, logic [7:0] ls);
    vec_t v;
    v.name = n; v.cycles = c; v.rst_n = r; v.locked = l; v.sw = s;
    v.pll_rst = pr; v.vrst_n = vr; v.ready = rd; v.fault = ft;
    v.retry = rt; v.loss = LossEn ? ls : 8'd0;
    vecs.push_back(v);
  endfunction

  task automatic check(string n, logic pr, logic vr, logic rd, logic ft,
                       logic [3:0] rt, logic [7:0] ls);
    logic [15:0] act, exp;
    act = {pll_rst, video_rst_n, ready, fault, retry_cnt, lock_loss_cnt};
    exp = {pr, vr, rd, ft, rt, ls};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {pll_rst,video_rst_n,ready,fault,retry,loss}=%h, expected %h",
               n, act, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;

    //  name            cyc rst lk sw  prst vrn rdy flt retry loss
    add("reset",          2, 0, 0, 0,  1,  0,  0,  0,  4'd0, 8'd0);
    // Scenario 1: bring-up with lock three cycles after pll_rst falls
    add("s1_pulse_hi",    3, 1, 0, 0,  1,  0,  0,  0,  4'd0, 8'd0);
    add("s1_pulse_lo",    1, 1, 0, 0,  0,  0,  0,  0,  4'd0, 8'd0);
    add("s1_wait",        2, 1, 0, 0,  0,  0,  0,  0,  4'd0, 8'd0);
    add("s1_pre_run",    10, 1, 1, 0,  0,  0,  0,  0,  4'd0, 8'd0);
    add("s1_run",         1, 1, 1, 0,  0,  1,  1,  0,  4'd0, 8'd0);
    // Scenario 4: lock loss in RUN
    add("s4_still_run",   2, 1, 0, 0,  0,  1,  1,  0,  4'd0, 8'd0);
    add("s4_lost",        1, 1, 0, 0,  1,  0,  0,  0,  4'd0, 8'd1);
    // Scenario 3: lock glitch in STABILIZE
    add("s3_relock",      4, 1, 1, 0,  0,  0,  0,  0,  4'd0, 8'd1);
    add("s3_glitch",      3, 1, 0, 0,  0,  0,  0,  0,  4'd0, 8'd1);
    add("s3_restab",      3, 1, 1, 0,  0,  0,  0,  0,  4'd0, 8'd1);
    add("s3_pre_run",     7, 1, 1, 0,  0,  0,  0,  0,  4'd0, 8'd1);
    add("s3_run",         1, 1, 1, 0,  0,  1,  1,  0,  4'd0, 8'd1);
    // Scenario 5: lock loss and sw_reset_req on the same FSM cycle
    add("s5_still_run",   2, 1, 0, 0,  0,  1,  1,  0,  4'd0, 8'd1);
    add("s5_both",        1, 1, 0, 1,  1,  0,  0,  0,  4'd0, 8'd2);
    add("s5_pulse_hi",    3, 1, 0, 0,  1,  0,  0,  0,  4'd0, 8'd2);
    add("s5_pulse_lo",    1, 1, 0, 0,  0,  0,  0,  0,  4'd0, 8'd2);
    // Scenario 2: no lock, two timeouts, FAULT, then sw_reset_req
    add("s2_wait1",      19, 1, 0, 0,  0,  0,  0,  0,  4'd0, 8'd2);
    add("s2_to1",         1, 1, 0, 0,  1,  0,  0,  0,  4'd1, 8'd2);
    add("s2_pulse2_hi",   3, 1, 0, 0,  1,  0,  0,  0,  4'd1, 8'd2);
    add("s2_pulse2_lo",   1, 1, 0, 0,  0,  0,  0,  0,  4'd1, 8'd2);
    add("s2_wait2",      19, 1, 0, 0,  0,  0,  0,  0,  4'd1, 8'd2);
    add("s2_fault",       1, 1, 0, 0,  1,  0,  0,  1,  4'd2, 8'd2);
    add("s2_fault_hold", 10, 1, 0, 0,  1,  0,  0,  1,  4'd2, 8'd2);
    add("s2_swreset",     1, 1, 0, 1,  1,  0,  0,  0,  4'd0, 8'd2);
    add("s2_pulse3_hi",   3, 1, 0, 0,  1,  0,  0,  0,  4'd0, 8'd2);
    add("s2_pulse3_lo",   1, 1, 0, 0,  0,  0,  0,  0,  4'd0, 8'd2);
    // Scenario 6 setup: one timeout, then sit in WAIT_LOCK with retry_cnt=1
    add("s6_wait",       19, 1, 0, 0,  0,  0,  0,  0,  4'd0, 8'd2);
    add("s6_to1",         1, 1, 0, 0,  1,  0,  0,  0,  4'd1, 8'd2);
    add("s6_pulse_lo",    4, 1, 0, 0,  0,  0,  0,  0,  4'd1, 8'd2);
    add("s6_mid_wait",    5, 1, 0, 0,  0,  0,  0,  0,  4'd1, 8'd2);

    @(negedge refclk);
    foreach (vecs[i]) begin
      rst_n        = vecs[i].rst_n;
      pll_locked   = vecs[i].locked;
      sw_reset_req = vecs[i].sw;
      repeat (vecs[i].cycles) @(negedge refclk);
      check(vecs[i].name, vecs[i].pll_rst, vecs[i].vrst_n, vecs[i].ready, vecs[i].fault,
            vecs[i].retry, vecs[i].loss);
    end

    // Scenario 6: asynchronous reset between clock edges.
    #1 rst_n = 1'b0;
    #1 check("s6_async_reset", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    repeat (3) @(negedge refclk);
    check("s6_reset_held", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
